// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, forward and inverse S-box tables,
// and the state encoding used by the sequential byte-substitution engines.
package aes_pkg;

    localparam int BLOCK_W   = 128;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } aes_state_e;

    function automatic logic [BYTE_W-1:0] fwd_sbox(input logic [BYTE_W-1:0] b);
        return SBOX_TBL[11'd2047 - {b, 3'b000} -: BYTE_W];
    endfunction

    function automatic logic [BYTE_W-1:0] inv_sbox(input logic [BYTE_W-1:0] b);
        return INV_SBOX_TBL[11'd2047 - {b, 3'b000} -: BYTE_W];
    endfunction

endpackage

// File: rtl/inv_sbox_lut.sv
// Combinational AES inverse S-box lookup for one byte.
module inv_sbox_lut
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout
);

    assign dout = inv_sbox(din);

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes: captures a 128-bit state, substitutes
// BYTES_PER_CYCLE bytes per cycle in place, then presents the result
// with a valid/ready handshake.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    localparam int NUM_STEPS = NUM_BYTES / BYTES_PER_CYCLE;
    localparam int STEP_W    = $clog2(NUM_STEPS) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    aes_state_e         state_r, state_s;
    logic [STEP_W-1:0]  step_r, step_s;
    logic [BLOCK_W-1:0] buf_r, buf_s;
    logic               in_ready_r, out_valid_r, busy_r;

    logic [3:0]         base_s;
    logic [BYTE_W-1:0]  cur_bytes_s [NUM_BYTES];
    logic [BYTE_W-1:0]  sub_bytes_s [NUM_BYTES];
    logic [BLOCK_W-1:0] sub_block_s;
    logic [BYTE_W-1:0]  lut_in_s    [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0]  lut_out_s   [BYTES_PER_CYCLE];

    // Byte view of the buffer; byte 0 is the most significant byte.
    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_bytes
        assign cur_bytes_s[k] = buf_r[BLOCK_W-1-BYTE_W*k -: BYTE_W];
        assign sub_block_s[BLOCK_W-1-BYTE_W*k -: BYTE_W] = sub_bytes_s[k];
    end

    // First byte index handled in the current step.
    always_comb begin
        base_s = 4'(32'(step_r) * BYTES_PER_CYCLE);
    end

    for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lut
        assign lut_in_s[i] = cur_bytes_s[base_s + 4'(i)];
        inv_sbox_lut u_lut (
            .din  (lut_in_s[i]),
            .dout (lut_out_s[i])
        );
    end

    // Buffer image with the current step's bytes replaced by their inverse.
    always_comb begin
        for (int k = 0; k < NUM_BYTES; k++) begin
            sub_bytes_s[k] = cur_bytes_s[k];
        end
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
            sub_bytes_s[base_s + 4'(i)] = lut_out_s[i];
        end
    end

    // Next-state, counter and buffer update logic.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        buf_s   = buf_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    buf_s   = in_data;
                    step_s  = '0;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                buf_s  = sub_block_s;
                step_s = step_r + STEP_W'(1);
                if (step_r == LAST_STEP) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                step_s  = '0;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            step_r      <= '0;
            buf_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            step_r      <= step_s;
            buf_r       <= buf_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = buf_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: default instance plus a parameter
// sweep of BYTES_PER_CYCLE = 1, 2, 8, 16 sharing the same stimulus.
module tb_inv_sub_bytes_seq;

    localparam logic [127:0] FIRST_ROW_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] FIRST_ROW_OUT = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CORNER_IN     = 128'h630016ed017c630016ed017c52525252;
    localparam logic [127:0] CORNER_OUT    = 128'h0052ff5309010052ff53090148484848;
    localparam logic [127:0] ZERO_OUT      = {16{8'h52}};
    localparam logic [127:0] ONES_OUT      = {16{8'h7d}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = 128'h0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic         sw_busy      [4];
    logic [127:0] sw_out_data  [4];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    localparam int SW_BPC [4] = '{1, 2, 8, 16};
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(SW_BPC[g])) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sw_in_ready[g]),
            .in_data(in_data), .out_valid(sw_out_valid[g]), .out_ready(out_ready),
            .out_data(sw_out_data[g]), .busy(sw_busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Apply one block on the main instance, measure latency, check and consume.
    task automatic run_block(input string tag, input logic [127:0] din,
                             input logic [127:0] exp, input bit check_lat);
        int lat;
        bit ready_seen;
        lat = 0;
        ready_seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
            if (in_ready) ready_seen = 1'b1;
        end
        if (check_lat) begin
            chk({tag, "_latency"}, 128'(lat), 128'(4));
            chk({tag, "_in_ready_low"}, 128'(ready_seen), 128'(0));
        end
        chk({tag, "_data"}, out_data, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(posedge clk);
        #1 chk({tag, "_back_to_idle"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] held, plain, cipher, blocks [4], expv [4];
        int acc_cyc [4];
        int sw_lat [4];
        int blk, got;

        do_reset();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_busy", 128'(busy), 128'(0));

        run_block("first_row", FIRST_ROW_IN, FIRST_ROW_OUT, 1'b1);
        run_block("corner", CORNER_IN, CORNER_OUT, 1'b1);

        // Round trip through the forward S-box.
        for (int r = 0; r < 100; r++) begin
            plain = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 16; k++) begin
                cipher[127-8*k -: 8] = aes_pkg::fwd_sbox(plain[127-8*k -: 8]);
            end
            run_block("roundtrip", cipher, plain, 1'b0);
        end

        // Output backpressure with a stray request while DONE.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = FIRST_ROW_IN;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 64 && !out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_valid", 128'(out_valid), 128'(1));
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_data  = CORNER_IN ^ 128'(k);
            in_valid = (k == 3);
            @(posedge clk);
            #1;
            chk("bp_stable", out_data, FIRST_ROW_OUT);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        chk("bp_held_unchanged", out_data, held);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(posedge clk);
        #1 chk("bp_idle", 128'(in_ready), 128'(1));
        run_block("bp_next", CORNER_IN, CORNER_OUT, 1'b1);

        // Reset at step 2.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = FIRST_ROW_IN;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_data", out_data, 128'h0);
        chk("mid_rst_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_block("after_rst", 128'h0, ZERO_OUT, 1'b1);

        // Parameter sweep.
        do_reset();
        for (int g = 0; g < 4; g++) sw_lat[g] = 0;
        in_valid = 1'b1;
        in_data  = FIRST_ROW_IN;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                if (sw_out_valid[g] && sw_lat[g] == 0) sw_lat[g] = k;
            end
        end
        chk("sweep1_lat", 128'(sw_lat[0]), 128'(16));
        chk("sweep2_lat", 128'(sw_lat[1]), 128'(8));
        chk("sweep8_lat", 128'(sw_lat[2]), 128'(2));
        chk("sweep16_lat", 128'(sw_lat[3]), 128'(1));
        for (int g = 0; g < 4; g++) chk("sweep_data", sw_out_data[g], FIRST_ROW_OUT);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Back-to-back traffic on the default instance.
        do_reset();
        blocks = '{FIRST_ROW_IN, CORNER_IN, 128'h0, {16{8'hff}}};
        expv   = '{FIRST_ROW_OUT, CORNER_OUT, ZERO_OUT, ONES_OUT};
        blk = 0;
        got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("b2b_data", out_data, expv[got]);
                got++;
            end
            if (in_ready) begin
                if (blk < 4) begin
                    in_data = blocks[blk];
                    in_valid = 1'b1;
                    acc_cyc[blk] = cyc;
                    blk++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 128'(got), 128'(4));
        for (int b = 1; b < 4; b++) chk("b2b_spacing", 128'(acc_cyc[b] - acc_cyc[b-1]), 128'(6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
